// File: rtl/inst_decode_queue_pkg.sv
// Shared types and decoder constants for the buffered decode stage.
package inst_decode_queue_pkg;

  typedef logic [31:0] word;

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_BAD = 3'd6
  } fmt_e;

  typedef struct packed {
    logic [6:0] opcode;
    fmt_e       fmt;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [2:0] funct3;
    logic [6:0] funct7;
    word        imm;
  } decode_struct;

  typedef struct packed {
    word          pc;
    decode_struct dec;
  } dq_entry_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;

endpackage

// File: rtl/inst_decode_queue_if.sv
// Fetch / issue handshake bundle of the decode queue.
interface inst_decode_queue_if
  import inst_decode_queue_pkg::*;
#(
  parameter int FETCH_WIDTH = 2,
  parameter int ISSUE_WIDTH = 2,
  parameter int DEPTH       = 8
) ();

  logic                               i_flush;
  logic [FETCH_WIDTH-1:0]             i_fetch_valid;
  word                                i_fetch_pc;
  word                                i_insts [FETCH_WIDTH];
  logic                               o_fetch_ready;
  logic [ISSUE_WIDTH-1:0]             o_issue_valid;
  word                                o_issue_pc [ISSUE_WIDTH];
  decode_struct                       o_decode_data [ISSUE_WIDTH];
  logic [$clog2(ISSUE_WIDTH+1)-1:0]   i_issue_count;
  logic [$clog2(DEPTH+1)-1:0]         o_count;

  modport master (
    output i_flush, i_fetch_valid, i_fetch_pc, i_insts, i_issue_count,
    input  o_fetch_ready, o_issue_valid, o_issue_pc, o_decode_data, o_count
  );

  modport slave (
    input  i_flush, i_fetch_valid, i_fetch_pc, i_insts, i_issue_count,
    output o_fetch_ready, o_issue_valid, o_issue_pc, o_decode_data, o_count
  );

endinterface

// File: rtl/inst_decode_queue_chk.sv
// Protocol checks on the fetch and issue handshakes of the decode queue.
module inst_decode_queue_chk #(
  parameter int FETCH_WIDTH = 2,
  parameter int ISSUE_WIDTH = 2,
  parameter int DEPTH       = 8
) (
  input logic                             i_clk,
  input logic                             i_rst,
  input logic [FETCH_WIDTH-1:0]           fetch_valid,
  input logic [$clog2(ISSUE_WIDTH+1)-1:0] issue_count,
  input logic [$clog2(DEPTH+1)-1:0]       count
);

  // Valid lanes must form a contiguous run starting at lane 0
  a_contig_valid: assert property (@(posedge i_clk) disable iff (i_rst)
    ((fetch_valid & (fetch_valid + FETCH_WIDTH'(1))) == '0));

  // Dispatch may never consume more entries than are queued
  a_issue_le_count: assert property (@(posedge i_clk) disable iff (i_rst)
    (32'(issue_count) <= 32'(count)));

endmodule

// File: rtl/inst_decode_queue_decode_lane.sv
// Single-lane combinational instruction decoder (raw word -> decode_struct).
module decode_lane
  import inst_decode_queue_pkg::*;
(
  input  word          inst,
  output decode_struct dec
);

  // Extract register fields and build the format-specific immediate
  always_comb begin
    dec        = '0;
    dec.opcode = inst[6:0];
    dec.rd     = inst[11:7];
    dec.funct3 = inst[14:12];
    dec.rs1    = inst[19:15];
    dec.rs2    = inst[24:20];
    dec.funct7 = inst[31:25];
    dec.fmt    = FMT_BAD;
    dec.imm    = 32'h0000_0000;
    case (inst[6:0])
      OP_REG: begin
        if ((inst[31:25] == F7_BASE) || (inst[31:25] == F7_ALT)) begin
          dec.fmt = FMT_R;
        end else begin
          dec.fmt = FMT_BAD;
        end
      end
      OP_IMM, OP_LOAD, OP_JALR: begin
        dec.fmt = FMT_I;
        dec.imm = {{20{inst[31]}}, inst[31:20]};
      end
      OP_STORE: begin
        dec.fmt = FMT_S;
        dec.imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      end
      OP_BRANCH: begin
        dec.fmt = FMT_B;
        dec.imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin
        dec.fmt = FMT_U;
        dec.imm = {inst[31:12], 12'h000};
      end
      OP_JAL: begin
        dec.fmt = FMT_J;
        dec.imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      end
      default: begin
        dec.fmt = FMT_BAD;
        dec.imm = 32'h0000_0000;
      end
    endcase
  end

endmodule

// File: rtl/inst_decode_queue.sv
// N-wide decode stage feeding a circular buffer of decoded instructions.
module inst_decode_queue
  import inst_decode_queue_pkg::*;
#(
  parameter int FETCH_WIDTH = 2,
  parameter int ISSUE_WIDTH = 2,
  parameter int DEPTH       = 8
) (
  input logic                i_clk,
  input logic                i_rst,
  inst_decode_queue_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0]       head_r;
  logic [PTR_W-1:0]       tail_r;
  logic [CNT_W-1:0]       count_r;
  logic [CNT_W-1:0]       count_nxt_s;
  logic [CNT_W-1:0]       enq_n_s;
  logic [CNT_W-1:0]       deq_n_s;
  logic                   ready_s;
  logic                   enq_s;
  logic [FETCH_WIDTH-1:0] wr_en_s;
  logic [PTR_W-1:0]       rd_idx_s;
  decode_struct           dec_s [FETCH_WIDTH];
  dq_entry_t              wr_entry_s [FETCH_WIDTH];
  dq_entry_t              mem_r [DEPTH];

  function automatic logic [CNT_W-1:0] popcount_f(input logic [FETCH_WIDTH-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      n = n + CNT_W'(v[k]);
    end
    return n;
  endfunction

  for (genvar g = 0; g < FETCH_WIDTH; g++) begin : g_lane
    decode_lane u_dec (
      .inst (bus.i_insts[g]),
      .dec  (dec_s[g])
    );
  end

  // Accept only when a full fetch group fits in the space free at cycle start
  always_comb begin
    ready_s = 1'b0;
    if (i_rst) begin
      ready_s = 1'b0;
    end else begin
      ready_s = (CNT_W'(DEPTH) - count_r) >= CNT_W'(FETCH_WIDTH);
    end
    enq_s       = ready_s && (bus.i_fetch_valid != '0) && !bus.i_flush;
    enq_n_s     = enq_s ? popcount_f(bus.i_fetch_valid) : '0;
    deq_n_s     = CNT_W'(bus.i_issue_count);
    count_nxt_s = count_r + enq_n_s - deq_n_s;
    wr_en_s     = enq_s ? bus.i_fetch_valid : '0;
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      wr_entry_s[k].pc  = bus.i_fetch_pc + (32'(k) * 32'd4);
      wr_entry_s[k].dec = dec_s[k];
    end
    bus.o_fetch_ready = ready_s;
    bus.o_count       = count_r;
  end

  // Head, tail and occupancy; flush empties the queue and beats enq/deq
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else if (bus.i_flush) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else begin
      head_r  <= head_r + PTR_W'(bus.i_issue_count);
      tail_r  <= tail_r + PTR_W'(enq_n_s);
      count_r <= count_nxt_s;
    end
  end

  // Write decoded lanes at the tail; storage is masked by count, never reset
  always_ff @(posedge i_clk) begin
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      if (wr_en_s[k]) begin
        mem_r[tail_r + PTR_W'(k)] <= wr_entry_s[k];
      end
    end
  end

  // Present the oldest entries in program order starting at head
  always_comb begin
    bus.o_issue_valid = '0;
    rd_idx_s          = '0;
    for (int k = 0; k < ISSUE_WIDTH; k++) begin
      rd_idx_s              = head_r + PTR_W'(k);
      bus.o_issue_valid[k]  = (CNT_W'(k) < count_r);
      bus.o_issue_pc[k]     = mem_r[rd_idx_s].pc;
      bus.o_decode_data[k]  = mem_r[rd_idx_s].dec;
    end
  end

  inst_decode_queue_chk #(
    .FETCH_WIDTH (FETCH_WIDTH),
    .ISSUE_WIDTH (ISSUE_WIDTH),
    .DEPTH       (DEPTH)
  ) u_chk (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .fetch_valid (bus.i_fetch_valid),
    .issue_count (bus.i_issue_count),
    .count       (count_r)
  );

endmodule

// File: tb/tb_inst_decode_queue.sv
// Table-driven bench with a scoreboard of expected issued entries.
module tb_inst_decode_queue;
  import inst_decode_queue_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  inst_decode_queue_if #(.FETCH_WIDTH(2), .ISSUE_WIDTH(2), .DEPTH(8)) bus ();

  inst_decode_queue #(.FETCH_WIDTH(2), .ISSUE_WIDTH(2), .DEPTH(8)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  typedef struct {
    word        pc;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    word        imm;
  } exp_t;

  typedef struct {
    logic [1:0] v;
    int         iss;
    logic       fl;
    logic       rdy;
    int         cnt;
  } vec_t;

  exp_t sb [$];
  vec_t vecs [23];
  int   n_cmp = 0;
  int   n_bad = 0;
  word  pc_next = 32'h0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  function automatic word gen_inst(input word pc);
    return {pc[13:2], pc[8:4], 3'b000, pc[6:2], 7'b0010011};
  endfunction

  function automatic exp_t exp_of(input word inst, input word pc);
    exp_t e;
    e.pc  = pc;
    e.rd  = inst[11:7];
    e.rs1 = inst[19:15];
    e.rs2 = inst[24:20];
    e.imm = (inst[6:0] == 7'b0010011) ? {{20{inst[31]}}, inst[31:20]} : 32'h0;
    return e;
  endfunction

  task automatic drive_raw(input logic [1:0] v, input word pc, input word i0, input word i1,
                           input int iss, input logic fl, input logic rdy, input int cnt,
                           input string nm);
    exp_t       e;
    logic [1:0] mask;
    bus.i_fetch_valid = v;
    bus.i_fetch_pc    = pc;
    bus.i_insts[0]    = i0;
    bus.i_insts[1]    = i1;
    bus.i_issue_count = 2'(iss);
    bus.i_flush       = fl;
    #1;
    mask = (cnt >= 2) ? 2'b11 : ((cnt == 1) ? 2'b01 : 2'b00);
    chk({nm, "/ready"}, 32'(bus.o_fetch_ready), 32'(rdy));
    chk({nm, "/count"}, 32'(bus.o_count), 32'(cnt));
    chk({nm, "/ivalid"}, 32'(bus.o_issue_valid), 32'(mask));
    for (int k = 0; k < iss; k++) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL %s/sb_empty: got lane %0d want queued entry", nm, k);
      end else begin
        e = sb.pop_front();
        chk($sformatf("%s/pc%0d", nm, k), bus.o_issue_pc[k], e.pc);
        chk($sformatf("%s/rd%0d", nm, k), 32'(bus.o_decode_data[k].rd), 32'(e.rd));
        chk($sformatf("%s/rs1_%0d", nm, k), 32'(bus.o_decode_data[k].rs1), 32'(e.rs1));
        chk($sformatf("%s/rs2_%0d", nm, k), 32'(bus.o_decode_data[k].rs2), 32'(e.rs2));
        chk($sformatf("%s/imm%0d", nm, k), bus.o_decode_data[k].imm, e.imm);
      end
    end
    if (fl) begin
      sb.delete();
      pc_next = pc + 32'h40;
    end else if (rdy && (v != 2'b00)) begin
      sb.push_back(exp_of(i0, pc));
      if (v[1]) begin
        sb.push_back(exp_of(i1, pc + 32'd4));
      end
      pc_next = pc + (v[1] ? 32'd8 : 32'd4);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t t, input string nm);
    drive_raw(t.v, pc_next, gen_inst(pc_next), gen_inst(pc_next + 32'd4),
              t.iss, t.fl, t.rdy, t.cnt, nm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // {valid, issue_count, flush, expected ready, expected count before edge}
    vecs[0]  = '{2'b11, 0, 1'b0, 1'b1, 2};
    vecs[1]  = '{2'b11, 0, 1'b0, 1'b1, 4};
    vecs[2]  = '{2'b01, 0, 1'b0, 1'b1, 6};
    vecs[3]  = '{2'b11, 0, 1'b0, 1'b0, 7};
    vecs[4]  = '{2'b11, 1, 1'b0, 1'b0, 7};
    vecs[5]  = '{2'b11, 0, 1'b0, 1'b1, 6};
    vecs[6]  = '{2'b11, 0, 1'b0, 1'b0, 8};
    vecs[7]  = '{2'b01, 1, 1'b0, 1'b0, 8};
    vecs[8]  = '{2'b00, 1, 1'b0, 1'b0, 7};
    vecs[9]  = '{2'b11, 2, 1'b0, 1'b1, 6};
    vecs[10] = '{2'b11, 2, 1'b0, 1'b1, 6};
    vecs[11] = '{2'b00, 2, 1'b0, 1'b1, 6};
    vecs[12] = '{2'b00, 2, 1'b0, 1'b1, 4};
    vecs[13] = '{2'b00, 2, 1'b0, 1'b1, 2};
    vecs[14] = '{2'b00, 0, 1'b0, 1'b1, 0};
    vecs[15] = '{2'b11, 0, 1'b0, 1'b1, 0};
    vecs[16] = '{2'b11, 2, 1'b0, 1'b1, 2};
    vecs[17] = '{2'b11, 2, 1'b0, 1'b1, 2};
    vecs[18] = '{2'b11, 2, 1'b0, 1'b1, 2};
    vecs[19] = '{2'b11, 2, 1'b0, 1'b1, 2};
    vecs[20] = '{2'b11, 2, 1'b0, 1'b1, 2};
    vecs[21] = '{2'b00, 2, 1'b0, 1'b1, 2};
    vecs[22] = '{2'b00, 0, 1'b0, 1'b1, 0};

    bus.i_flush       = 1'b0;
    bus.i_fetch_valid = 2'b00;
    bus.i_fetch_pc    = 32'h0;
    bus.i_insts[0]    = 32'h0;
    bus.i_insts[1]    = 32'h0;
    bus.i_issue_count = 2'd0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst/ready", 32'(bus.o_fetch_ready), 32'h0);
    chk("rst/count", 32'(bus.o_count), 32'h0);
    chk("rst/ivalid", 32'(bus.o_issue_valid), 32'h0);
    rst = 1'b0;

    // addi x1,x0,5 ; add x2,x1,x1 at PC 0
    drive_raw(2'b11, 32'h0, 32'h0050_0093, 32'h0010_8133, 0, 1'b0, 1'b1, 0, "t1");
    chk("t1/count", 32'(bus.o_count), 32'd2);
    chk("t1/pc0", bus.o_issue_pc[0], 32'h0);
    chk("t1/rd0", 32'(bus.o_decode_data[0].rd), 32'd1);
    chk("t1/imm0", bus.o_decode_data[0].imm, 32'd5);
    chk("t1/pc1", bus.o_issue_pc[1], 32'h4);
    chk("t1/rd1", 32'(bus.o_decode_data[1].rd), 32'd2);
    chk("t1/rs1_1", 32'(bus.o_decode_data[1].rs1), 32'd1);
    chk("t1/rs2_1", 32'(bus.o_decode_data[1].rs2), 32'd1);

    // fill, full boundary, simultaneous enq/deq, drain and wrap
    for (int i = 0; i < 23; i++) begin
      drive(vecs[i], $sformatf("v%0d", i));
    end

    // flush at count 5 while offering two lanes
    drive('{2'b11, 0, 1'b0, 1'b1, 0}, "f0");
    drive('{2'b11, 0, 1'b0, 1'b1, 2}, "f1");
    drive('{2'b01, 0, 1'b0, 1'b1, 4}, "f2");
    drive('{2'b11, 0, 1'b1, 1'b1, 5}, "f3");
    drive('{2'b00, 0, 1'b0, 1'b1, 0}, "f4");
    drive('{2'b11, 0, 1'b0, 1'b1, 0}, "f5");
    drive('{2'b00, 2, 1'b0, 1'b1, 2}, "f6");

    // asynchronous reset pulse mid-stream at count 4
    drive('{2'b11, 0, 1'b0, 1'b1, 0}, "r0");
    drive('{2'b11, 0, 1'b0, 1'b1, 2}, "r1");
    bus.i_fetch_valid = 2'b00;
    bus.i_issue_count = 2'd0;
    chk("r1/count_pre", 32'(bus.o_count), 32'd4);
    rst = 1'b1;
    #1;
    chk("rst_mid/count", 32'(bus.o_count), 32'h0);
    chk("rst_mid/ready", 32'(bus.o_fetch_ready), 32'h0);
    chk("rst_mid/ivalid", 32'(bus.o_issue_valid), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    pc_next = 32'h100;
    drive('{2'b01, 0, 1'b0, 1'b1, 0}, "r2");
    chk("r2/ivalid", 32'(bus.o_issue_valid), 32'h1);
    chk("r2/pc0", bus.o_issue_pc[0], 32'h100);
    drive('{2'b00, 1, 1'b0, 1'b1, 1}, "r3");
    drive('{2'b00, 0, 1'b0, 1'b1, 0}, "r4");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
